seven_segment_scan_driver: RTL
==============================

SEVEN_SEGMENT_SCAN_DRIVER -- requirements
Module: seven_segment_scan_driver

Interface
REQ-001 Parameter: TICK_DIV, default 50000, clock cycles per digit dwell; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 enable  input  1  1 = scanning active, 0 = display off.
REQ-005 value_in  input  16  four hex digits to show; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 load  input  1  single-cycle request to capture value_in.
REQ-007 blank_lz  input  1  1 = blank leading zeros.
REQ-008 digit_nibble  output  4  nibble of the active digit, fed to the hex-to-segment converter.
REQ-009 digit_sel  output  4  one-hot active-high digit enable, bit i = digit i; all-zero when off.
REQ-010 digit_blank  output  1  1 = active digit must be blanked downstream.
REQ-011 frame_done  output  1  one-cycle pulse at each completed 4-digit frame.

Function
REQ-012 All outputs shall be driven directly from registers, with no combinational path from any input to any output.
REQ-013 FSM states shall be IDLE, D0, D1, D2 and D3, with digit_sel equal to 0000, 0001, 0010, 0100 and 1000 respectively.
REQ-014 Prescaler counter: in states D0-D3, count 0..TICK_DIV-1; tick = counter at TICK_DIV-1; counter wraps to 0 on tick.
REQ-015 On tick, the FSM shall advance D0->D1->D2->D3->D0, so each digit dwells exactly TICK_DIV cycles.
REQ-016 enable=0 in any state: the FSM shall enter IDLE on the next edge and clear the prescaler to 0; digit_nibble and digit_blank shall also be 0.
REQ-017 IDLE with enable=1: the FSM shall enter D0 on the next edge with the prescaler at 0.
REQ-018 load=1 outside a frame boundary: value_in shall be stored in the pending register and pending_valid set; a later load overwrites pending (last wins).
REQ-019 Frame boundary = tick in D3; at that edge, if pending_valid=1, shadow <= pending and pending_valid <= 0.
REQ-020 load coincident with a frame boundary: shadow <= value_in directly, pending_valid <= 0, and any older pending value is discarded.
REQ-021 load in IDLE: shadow <= value_in immediately, pending_valid <= 0.
REQ-022 digit_nibble shall equal shadow[4i+3:4i] for the digit i being entered, updated on the same edge as digit_sel.
REQ-023 Blanking, blank_lz=1: digit i (i>=1) is blanked when shadow nibbles i..3 are all zero; digit 0 is never blanked; blank_lz=0 means no blanking.
REQ-024 blank_lz and shadow shall be sampled on the edge that enters the digit.
REQ-025 frame_done shall be 1 for exactly the one cycle following the D3->D0 transition, and shall never assert on IDLE->D0.
REQ-026 Shadow shall change only at frame boundaries or in IDLE, so a frame never mixes old and new values.

Reset
REQ-027 rst_n=0 shall immediately force: state IDLE, prescaler 0, shadow 0, pending 0, pending_valid 0, digit_sel 0000, digit_nibble 0, digit_blank 0, frame_done 0.
REQ-028 Reset mid-frame shall discard the pending load; after release with enable=1, scanning shall begin at D0 on the first edge.
REQ-029 Reset release shall be safe at any edge, with no output glitch beyond the reset values.

Verification (TICK_DIV=4)
REQ-030 Reset, enable=1, load 0x1234 in IDLE -> digit_sel 0001/0010/0100/1000 for 4 cycles each with nibbles 4,3,2,1; frame_done pulse after the D3->D0 transition.
REQ-031 Load 0xABCD during D1 while showing 0x1234 -> the rest of that frame still shows 3,2,1; the next frame shows D,C,B,A.
REQ-032 Two loads in one frame (0x1111, then 0x2222) -> the next frame shows 2,2,2,2.
REQ-033 Load 0x5678 on the D3 tick cycle -> the next frame shows 8,7,6,5 and pending_valid=0.
REQ-034 blank_lz=1, shadow 0x0050 -> digit_blank 0,0,1,1 for D0..D3; shadow 0x0000 -> blank 0,1,1,1.
REQ-035 Drop enable in D2 -> IDLE next edge with all outputs 0; re-enable -> D0, and no frame_done until the first D3->D0.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver: walks digits 0..3 with a fixed dwell,
// double-buffers the displayed value so a frame never mixes old and new digits.
module seven_segment_scan_driver #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit_nibble,
  output logic [3:0]  digit_sel,
  output logic        digit_blank,
  output logic        frame_done
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_D0   = 3'd1;
  localparam logic [2:0] S_D1   = 3'd2;
  localparam logic [2:0] S_D2   = 3'd3;
  localparam logic [2:0] S_D3   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic [3:0]       digit_sel_q, digit_sel_d;
  logic [3:0]       digit_nibble_q, digit_nibble_d;
  logic             digit_blank_q, digit_blank_d;
  logic             frame_done_q, frame_done_d;

  logic       scanning;
  logic       tick;
  logic       boundary;
  logic [1:0] cur_idx;
  logic [3:0] lz_blank;

  assign scanning = (state_q != S_IDLE);
  assign tick     = scanning && (cnt_q == CNT_LAST);
  assign boundary = enable && tick && (state_q == S_D3);
  assign cur_idx  = 2'(state_q - S_D0);

  // Value buffering: IDLE and frame boundaries update the shadow, anything else parks in pending.
  always_comb begin
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (!scanning || boundary) begin
      if (load) begin
        shadow_d        = value_in;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        shadow_d        = pending_q;
        pending_valid_d = 1'b0;
      end
    end else if (load) begin
      pending_d       = value_in;
      pending_valid_d = 1'b1;
    end
  end

  // Leading-zero blanking of the value about to be shown; digit 0 always stays lit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_blank
      if (gi == 0) begin : g_d0
        assign lz_blank[gi] = 1'b0;
      end else begin : g_dn
        assign lz_blank[gi] = blank_lz && (shadow_d[15:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    logic       enter;
    logic [1:0] next_idx;
    state_d        = state_q;
    cnt_d          = cnt_q;
    digit_sel_d    = digit_sel_q;
    digit_nibble_d = digit_nibble_q;
    digit_blank_d  = digit_blank_q;
    frame_done_d   = 1'b0;
    enter          = 1'b0;
    next_idx       = 2'd0;

    if (!enable) begin
      state_d        = S_IDLE;
      cnt_d          = '0;
      digit_sel_d    = 4'b0000;
      digit_nibble_d = 4'h0;
      digit_blank_d  = 1'b0;
    end else if (!scanning) begin
      state_d  = S_D0;
      cnt_d    = '0;
      enter    = 1'b1;
      next_idx = 2'd0;
    end else if (tick) begin
      next_idx     = cur_idx + 2'd1;
      state_d      = 3'(S_D0 + {1'b0, next_idx});
      cnt_d        = '0;
      enter        = 1'b1;
      frame_done_d = (state_q == S_D3);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (enter) begin
      digit_sel_d    = 4'b0001 << next_idx;
      digit_nibble_d = shadow_d[4*next_idx +: 4];
      digit_blank_d  = lz_blank[next_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      digit_sel_q     <= 4'b0000;
      digit_nibble_q  <= 4'h0;
      digit_blank_q   <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      digit_sel_q     <= digit_sel_d;
      digit_nibble_q  <= digit_nibble_d;
      digit_blank_q   <= digit_blank_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign digit_sel    = digit_sel_q;
  assign digit_nibble = digit_nibble_q;
  assign digit_blank  = digit_blank_q;
  assign frame_done   = frame_done_q;

endmodule
